// File: rtl/da_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : da_sequencer_if
//  Description : Sample/result handshakes and DA datapath controls of the
//                DA FIR sequencer.
//  Revision    : 1.0
// ============================================================================
interface da_sequencer_if #(
    parameter int CNT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic             tap_shift;
    logic             load;
    logic             enable;
    logic             acc_clear;
    logic             acc_en;
    logic             acc_sub;
    logic [CNT_W-1:0] bit_idx;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [15:0]      sample_cnt;

    modport master (
        input  in_valid, out_ready,
        output in_ready, tap_shift, load, enable, acc_clear, acc_en, acc_sub,
               bit_idx, out_valid, busy, sample_cnt
    );

    modport slave (
        output in_valid, out_ready,
        input  in_ready, tap_shift, load, enable, acc_clear, acc_en, acc_sub,
               bit_idx, out_valid, busy, sample_cnt
    );
endinterface
`default_nettype wire

// File: rtl/da_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : da_sequencer
//  Description : Control FSM of the distributed-arithmetic FIR core: accepts a
//                sample, loads and bit-serially shifts the register bank,
//                steers the accumulator and hands the result downstream.
//  Revision    : 1.0
// ============================================================================
module da_sequencer #(
    parameter int DATA_W   = 16,
    parameter int PIPE_LAT = 2,
    parameter int CNT_W    = 5
) (
    input  logic           clk,
    input  logic           reset,
    da_sequencer_if.master bus
);

    localparam int DRN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_SHIFT = 3'd2;
    localparam logic [2:0] c_ST_DRAIN = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] c_BIT_LAST   = CNT_W'(DATA_W - 1);
    localparam logic [DRN_W-1:0] c_DRAIN_LAST = DRN_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
    localparam logic [2:0]       c_ST_AFTER_SHIFT = (PIPE_LAT > 0) ? c_ST_DRAIN : c_ST_DONE;

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_bit_idx;
    logic [DRN_W-1:0] r_drain_cnt;
    logic [15:0]      r_sample_cnt;
    logic             w_run;
    logic             w_in_shift;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (bus.in_valid) w_state_nxt = c_ST_LOAD;
            c_ST_LOAD:  w_state_nxt = c_ST_SHIFT;
            c_ST_SHIFT: if (r_bit_idx == c_BIT_LAST) w_state_nxt = c_ST_AFTER_SHIFT;
            c_ST_DRAIN: if (r_drain_cnt == c_DRAIN_LAST) w_state_nxt = c_ST_DONE;
            c_ST_DONE:  if (bus.out_ready) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // bit_idx keeps the sign-slice index through DRAIN/DONE and is only
    // returned to zero when the result leaves.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_bit_idx    <= '0;
            r_drain_cnt  <= '0;
            r_sample_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_ST_LOAD: r_bit_idx <= '0;
                c_ST_SHIFT: begin
                    if (r_bit_idx != c_BIT_LAST) begin
                        r_bit_idx <= r_bit_idx + CNT_W'(1);
                    end
                end
                c_ST_DRAIN: begin
                    if (r_drain_cnt == c_DRAIN_LAST) begin
                        r_drain_cnt <= '0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DRN_W'(1);
                    end
                end
                c_ST_DONE: begin
                    if (bus.out_ready) begin
                        r_bit_idx    <= '0;
                        r_sample_cnt <= r_sample_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Every output is forced low while reset is held, even mid-sequence.
    assign w_run      = ~reset;
    assign w_in_shift = w_run & (r_state == c_ST_SHIFT);

    assign bus.in_ready   = w_run & (r_state == c_ST_IDLE);
    assign bus.tap_shift  = w_run & (r_state == c_ST_IDLE) & bus.in_valid;
    assign bus.load       = w_run & (r_state == c_ST_LOAD);
    assign bus.acc_clear  = w_run & (r_state == c_ST_LOAD);
    assign bus.enable     = w_in_shift;
    assign bus.acc_en     = w_in_shift;
    assign bus.acc_sub    = w_in_shift & (r_bit_idx == c_BIT_LAST);
    assign bus.bit_idx    = w_run ? r_bit_idx : '0;
    assign bus.out_valid  = w_run & (r_state == c_ST_DONE);
    assign bus.busy       = w_run & (r_state != c_ST_IDLE);
    assign bus.sample_cnt = w_run ? r_sample_cnt : '0;

endmodule
`default_nettype wire
